// File: rtl/adc_spi_responder.sv
// SPI slave model of an 8-channel 12-bit serial ADC. SCLK/CSN/DIN are oversampled in the fastClk domain.
// DOUT returns {0, ADD, D} for the channel selected by the previous frame's control word.
module adc_spi_responder #(
  parameter int DATA_WIDTH  = 12,
  parameter int NUM_CHAN    = 8,
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 1
) (
  input  logic                           fastClk,
  input  logic                           resetN,
  input  logic                           SCLK,
  input  logic                           CSN,
  input  logic                           DIN,
  output logic                           DOUT,
  input  logic [NUM_CHAN*DATA_WIDTH-1:0] chanData,
  output logic [$clog2(NUM_CHAN)-1:0]    addrReg,
  output logic [1:0]                     pmBits,
  output logic                           rangeBit,
  output logic                           codingBit,
  output logic [DATA_WIDTH-1:0]          ctrlWord,
  output logic                           frameDone,
  output logic                           frameAbort,
  output logic                           busy
);

  localparam int ADDR_W = $clog2(NUM_CHAN);
  localparam int CNT_W  = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS);
  localparam logic [DATA_WIDTH-1:0] MSB_MASK = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE,
    S_WAIT_CS
  } state_t;

  // Sampling pipeline: bit 2 = SCLK, bit 1 = CSN, bit 0 = DIN. CSN resets high so no false fall.
  logic [2:0] r_sync [SYNC_STAGES];
  logic [2:0] r_hist;

  always_ff @(posedge fastClk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 3'b010;
      r_hist <= 3'b010;
    end else begin
      r_sync[0] <= {SCLK, CSN, DIN};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  logic [2:0] w_smp;
  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic       w_csn_rise;
  logic       w_csn_fall;
  logic       w_din;

  assign w_smp       = r_sync[SYNC_STAGES-1];
  assign w_sclk_rise =  w_smp[2] & ~r_hist[2];
  assign w_sclk_fall = ~w_smp[2] &  r_hist[2];
  assign w_csn_rise  =  w_smp[1] & ~r_hist[1];
  assign w_csn_fall  = ~w_smp[1] &  r_hist[1];
  assign w_din       =  w_smp[0];

  state_t                  r_state;
  logic [FRAME_BITS-1:0]   r_tx_shift;
  logic [FRAME_BITS-1:0]   r_rx_shift;
  logic [CNT_W-1:0]        r_rise_cnt;
  logic [CNT_W-1:0]        r_fall_cnt;
  logic                    r_dout;
  logic [ADDR_W-1:0]       r_addr;
  logic [1:0]              r_pm;
  logic                    r_range;
  logic                    r_coding;
  logic [DATA_WIDTH-1:0]   r_ctrl;
  logic                    r_abort;

  state_t                  w_state_next;
  logic [FRAME_BITS-1:0]   w_tx_next;
  logic [FRAME_BITS-1:0]   w_rx_next;
  logic [CNT_W-1:0]        w_rise_next;
  logic [CNT_W-1:0]        w_fall_next;
  logic                    w_dout_next;
  logic [ADDR_W-1:0]       w_addr_next;
  logic [1:0]              w_pm_next;
  logic                    w_range_next;
  logic                    w_coding_next;
  logic [DATA_WIDTH-1:0]   w_ctrl_next;
  logic                    w_abort_next;

  logic [DATA_WIDTH-1:0]   w_sample;
  logic [DATA_WIDTH-1:0]   w_coded;
  logic [FRAME_BITS-1:0]   w_tx_word;
  logic [DATA_WIDTH-1:0]   w_rx_ctrl;

  // Two's complement output is the straight-binary sample with its MSB flipped.
  assign w_sample  = chanData[int'(r_addr)*DATA_WIDTH +: DATA_WIDTH];
  assign w_coded   = r_coding ? w_sample : (w_sample ^ MSB_MASK);
  assign w_tx_word = FRAME_BITS'({1'b0, r_addr, w_coded});
  assign w_rx_ctrl = r_rx_shift[FRAME_BITS-1 -: DATA_WIDTH];

  always_ff @(posedge fastClk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= S_IDLE;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rise_cnt <= '0;
      r_fall_cnt <= '0;
      r_dout     <= 1'b0;
      r_addr     <= '0;
      r_pm       <= 2'b11;
      r_range    <= 1'b0;
      r_coding   <= 1'b1;
      r_ctrl     <= '0;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_tx_shift <= w_tx_next;
      r_rx_shift <= w_rx_next;
      r_rise_cnt <= w_rise_next;
      r_fall_cnt <= w_fall_next;
      r_dout     <= w_dout_next;
      r_addr     <= w_addr_next;
      r_pm       <= w_pm_next;
      r_range    <= w_range_next;
      r_coding   <= w_coding_next;
      r_ctrl     <= w_ctrl_next;
      r_abort    <= w_abort_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_tx_next     = r_tx_shift;
    w_rx_next     = r_rx_shift;
    w_rise_next   = r_rise_cnt;
    w_fall_next   = r_fall_cnt;
    w_dout_next   = 1'b0;
    w_addr_next   = r_addr;
    w_pm_next     = r_pm;
    w_range_next  = r_range;
    w_coding_next = r_coding;
    w_ctrl_next   = r_ctrl;
    w_abort_next  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_csn_fall) begin
          w_tx_next    = w_tx_word;
          w_dout_next  = w_tx_word[FRAME_BITS-1];
          w_rise_next  = '0;
          w_fall_next  = '0;
          w_rx_next    = '0;
          w_state_next = S_SHIFT;
        end
      end

      S_SHIFT: begin
        w_dout_next = r_dout;
        // CSN wins over a same-cycle SCLK edge, so a late 16th fall still aborts.
        if (w_csn_rise) begin
          w_abort_next = 1'b1;
          w_dout_next  = 1'b0;
          w_state_next = S_IDLE;
        end else if (w_sclk_rise) begin
          if (r_rise_cnt < LAST_CNT) begin
            w_rise_next = r_rise_cnt + CNT_W'(1);
            w_tx_next   = {r_tx_shift[FRAME_BITS-2:0], 1'b0};
            w_dout_next = r_tx_shift[FRAME_BITS-2];
          end
        end else if (w_sclk_fall) begin
          if (r_fall_cnt < LAST_CNT) begin
            w_rx_next   = {r_rx_shift[FRAME_BITS-2:0], w_din};
            w_fall_next = r_fall_cnt + CNT_W'(1);
            if (r_fall_cnt == LAST_CNT - CNT_W'(1)) begin
              w_dout_next  = 1'b0;
              w_state_next = S_DONE;
            end
          end
        end
      end

      S_DONE: begin
        w_ctrl_next = w_rx_ctrl;
        if (w_rx_ctrl[DATA_WIDTH-1]) begin
          w_addr_next   = w_rx_ctrl[6 +: ADDR_W];
          w_pm_next     = w_rx_ctrl[5:4];
          w_range_next  = w_rx_ctrl[1];
          w_coding_next = w_rx_ctrl[0];
        end
        // A CSN rise seen during this single cycle must not strand us in WAIT_CS.
        w_state_next = w_csn_rise ? S_IDLE : S_WAIT_CS;
      end

      S_WAIT_CS: begin
        if (w_csn_rise) w_state_next = S_IDLE;
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  assign DOUT       = r_dout;
  assign addrReg    = r_addr;
  assign pmBits     = r_pm;
  assign rangeBit   = r_range;
  assign codingBit  = r_coding;
  assign ctrlWord   = r_ctrl;
  assign frameDone  = (r_state == S_DONE);
  assign frameAbort = r_abort;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: acts as SPI master and compares against a frame-level model.
module tb_adc_spi_responder;

  logic        fastClk = 1'b0;
  logic        resetN;
  logic        SCLK;
  logic        CSN;
  logic        DIN;
  logic        DOUT;
  logic [95:0] chanData;
  logic [2:0]  addrReg;
  logic [1:0]  pmBits;
  logic        rangeBit;
  logic        codingBit;
  logic [11:0] ctrlWord;
  logic        frameDone;
  logic        frameAbort;
  logic        busy;

  always #10 fastClk = ~fastClk;

  adc_spi_responder dut (
    .fastClk   (fastClk),
    .resetN    (resetN),
    .SCLK      (SCLK),
    .CSN       (CSN),
    .DIN       (DIN),
    .DOUT      (DOUT),
    .chanData  (chanData),
    .addrReg   (addrReg),
    .pmBits    (pmBits),
    .rangeBit  (rangeBit),
    .codingBit (codingBit),
    .ctrlWord  (ctrlWord),
    .frameDone (frameDone),
    .frameAbort(frameAbort),
    .busy      (busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_frames = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  always @(posedge fastClk) begin
    if (frameDone)  done_cnt  <= done_cnt + 1;
    if (frameAbort) abort_cnt <= abort_cnt + 1;
  end

  // Frame-level reference state
  logic [11:0] m_ch [8];
  logic [2:0]  m_addr;
  logic [1:0]  m_pm;
  logic        m_range;
  logic        m_coding;
  logic [11:0] m_ctrl;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_addr   = 3'd0;
    m_pm     = 2'd3;
    m_range  = 1'b0;
    m_coding = 1'b1;
    m_ctrl   = 12'd0;
  endtask

  task automatic push_chan();
    for (int i = 0; i < 8; i++) chanData[i*12 +: 12] = m_ch[i];
  endtask

  function automatic logic [15:0] exp_word();
    int v;
    v = int'(m_ch[m_addr]);
    if (!m_coding) v = (v + 2048) % 4096;
    return 16'(int'(m_addr) * 4096 + v);
  endfunction

  task automatic clock_bit(input logic din_bit);
    DIN = din_bit;
    @(negedge fastClk);
    SCLK = 1'b1;
    repeat (3) @(negedge fastClk);
    SCLK = 1'b0;
    repeat (3) @(negedge fastClk);
  endtask

  task automatic frame(input logic [15:0] din_word, input int nbits, output logic [15:0] dout_word);
    logic [15:0] exp;
    logic [15:0] got_part;
    logic [15:0] exp_part;
    int d0;
    int a0;
    exp = exp_word();
    d0 = done_cnt;
    a0 = abort_cnt;
    dout_word = 16'h0;
    @(negedge fastClk);
    CSN = 1'b0;
    repeat (4) @(negedge fastClk);
    for (int b = 0; b < nbits; b++) begin
      dout_word[15-b] = DOUT;
      if (b == 8) check_val("busy_mid", 32'(busy), 32'd1);
      clock_bit(din_word[15-b]);
    end
    CSN = 1'b1;
    DIN = 1'b0;
    repeat (6) @(negedge fastClk);
    n_frames++;
    $display("frame %0d din=%h bits=%0d dout=%h exp=%h", n_frames, din_word, nbits, dout_word, exp);
    if (nbits == 16) begin
      check_val("dout_word", 32'(dout_word), 32'(exp));
      check_val("done_pulses", 32'(done_cnt - d0), 32'd1);
      check_val("abort_pulses", 32'(abort_cnt - a0), 32'd0);
      m_ctrl = din_word[15:4];
      if (m_ctrl[11]) begin
        m_addr   = m_ctrl[8:6];
        m_pm     = m_ctrl[5:4];
        m_range  = m_ctrl[1];
        m_coding = m_ctrl[0];
      end
    end else begin
      check_val("done_pulses_abort", 32'(done_cnt - d0), 32'd0);
      check_val("abort_pulses_abort", 32'(abort_cnt - a0), 32'd1);
      if (nbits > 0) begin
        got_part = dout_word >> (16 - nbits);
        exp_part = exp >> (16 - nbits);
        check_val("dout_partial", 32'(got_part), 32'(exp_part));
      end
    end
    check_val("ctrlWord", 32'(ctrlWord), 32'(m_ctrl));
    check_val("addrReg", 32'(addrReg), 32'(m_addr));
    check_val("pmBits", 32'(pmBits), 32'(m_pm));
    check_val("rangeBit", 32'(rangeBit), 32'(m_range));
    check_val("codingBit", 32'(codingBit), 32'(m_coding));
    check_val("busy_idle", 32'(busy), 32'd0);
    check_val("dout_idle", 32'(DOUT), 32'd0);
  endtask

  initial begin
    logic [15:0] w;
    logic [11:0] ctl;
    int a0;
    int nb;

    resetN = 1'b0;
    SCLK = 1'b0;
    CSN = 1'b1;
    DIN = 1'b0;
    for (int i = 0; i < 8; i++) m_ch[i] = 12'($urandom);
    m_ch[0] = 12'hABC;
    push_chan();
    model_reset();
    repeat (5) @(negedge fastClk);
    check_val("rst_dout", 32'(DOUT), 32'd0);
    check_val("rst_addr", 32'(addrReg), 32'd0);
    check_val("rst_pm", 32'(pmBits), 32'd3);
    check_val("rst_range", 32'(rangeBit), 32'd0);
    check_val("rst_coding", 32'(codingBit), 32'd1);
    check_val("rst_ctrl", 32'(ctrlWord), 32'd0);
    check_val("rst_done", 32'(frameDone), 32'd0);
    check_val("rst_abort", 32'(frameAbort), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    resetN = 1'b1;
    repeat (4) @(negedge fastClk);

    // Basic read of ch0 with a no-write control word
    frame(16'h0000, 16, w);
    check_val("t1_dout", 32'(w), 32'h0ABC);

    // Write ch5/CODING=1, then a WRITE=0 word that must leave config alone
    m_ch[5] = 12'h123;
    push_chan();
    frame({12'b1_0_0_101_11_0_0_1_1, 4'h0}, 16, w);
    frame({12'h3FF, 4'h0}, 16, w);
    check_val("t2_dout", 32'(w), 32'h5123);
    check_val("t4_ctrl", 32'(ctrlWord), 32'h3FF);
    check_val("t4_addr", 32'(addrReg), 32'd5);
    check_val("t4_pm", 32'(pmBits), 32'd3);

    // Two's complement coding flips the MSB of the returned sample
    frame({12'b1_0_0_101_11_0_0_1_0, 4'h0}, 16, w);
    frame(16'h0000, 16, w);
    check_val("t3_dout", 32'(w), 32'h5923);

    // Abort after 9 SCLK cycles with a write word that would move addr to 2
    frame({12'b1_0_0_010_11_0_0_1_1, 4'h0}, 9, w);
    check_val("t5_addr", 32'(addrReg), 32'd5);

    // Reset in the middle of a frame
    a0 = abort_cnt;
    @(negedge fastClk);
    CSN = 1'b0;
    repeat (4) @(negedge fastClk);
    for (int b = 0; b < 7; b++) clock_bit(1'b1);
    resetN = 1'b0;
    #1;
    check_val("t6_dout", 32'(DOUT), 32'd0);
    check_val("t6_addr", 32'(addrReg), 32'd0);
    check_val("t6_coding", 32'(codingBit), 32'd1);
    check_val("t6_busy", 32'(busy), 32'd0);
    CSN = 1'b1;
    SCLK = 1'b0;
    DIN = 1'b0;
    repeat (3) @(negedge fastClk);
    resetN = 1'b1;
    model_reset();
    repeat (4) @(negedge fastClk);
    check_val("t6_no_abort", 32'(abort_cnt - a0), 32'd0);
    frame(16'h0000, 16, w);
    check_val("t6_ch0", 32'(w), 32'(m_ch[0]));

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < 8; i++) m_ch[i] = 12'($urandom);
        push_chan();
      end
      ctl = 12'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 16;
      frame({ctl, 4'($urandom)}, nb, w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
